// File: rtl/operand_fwd_ctrl_if.sv
// Decode-side request and X-stage select/hazard bundle for operand_fwd_ctrl.
// The requester (decode/testbench) is the master; the controller is the slave.
interface operand_fwd_ctrl_if;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;

    logic              stall_in;
    logic              flush;
    logic              d_valid;
    logic [REG_W-1:0]  d_rs1;
    logic [REG_W-1:0]  d_rs2;
    logic              d_rs1_used;
    logic              d_rs2_used;
    logic [REG_W-1:0]  d_rd;
    logic              d_we;
    logic              d_is_load;
    logic [DATA_W-1:0] w_wdata;

    logic [SEL_W-1:0]  sel_a;
    logic [SEL_W-1:0]  sel_b;
    logic [DATA_W-1:0] retired_data;
    logic              x_valid;
    logic              w_valid;
    logic              stall_d;
    logic [DATA_W-1:0] stall_cnt;

    modport master (
        output stall_in, flush, d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used,
               d_rd, d_we, d_is_load, w_wdata,
        input  sel_a, sel_b, retired_data, x_valid, w_valid, stall_d, stall_cnt
    );

    modport slave (
        input  stall_in, flush, d_valid, d_rs1, d_rs2, d_rs1_used, d_rs2_used,
               d_rd, d_we, d_is_load, w_wdata,
        output sel_a, sel_b, retired_data, x_valid, w_valid, stall_d, stall_cnt
    );
endinterface

// File: rtl/operand_fwd_ctrl.sv
// Forwarding/hazard controller for the D/X/W pipeline: registered operand selects,
// retired-value hold register and load-use stall. Define LOAD_FWD_EN to forward loads from W.
module operand_fwd_ctrl (
    input logic               clk,
    input logic               rst,
    operand_fwd_ctrl_if.slave bus
);
    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 2;

    localparam logic [SEL_W-1:0] SEL_RF   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_ALU  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_HOLD = 2'b11;
`ifdef LOAD_FWD_EN
    localparam logic [SEL_W-1:0] SEL_X_LOAD = 2'b10;
`else
    // Unreachable without load forwarding: a load hit in X always stalls or bubbles.
    localparam logic [SEL_W-1:0] SEL_X_LOAD = 2'b00;
`endif

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             we;
        logic             is_load;
    } slot_t;

    slot_t              x_q;
    slot_t              w_q;
    slot_t              x_d;
    logic [SEL_W-1:0]   sel_a_q;
    logic [SEL_W-1:0]   sel_b_q;
    logic [SEL_W-1:0]   sel_a_d;
    logic [SEL_W-1:0]   sel_b_d;
    logic [DATA_W-1:0]  retired_q;
    logic [DATA_W-1:0]  stall_cnt_q;
    logic               stall_c;
    logic               bubble_c;
    logic               retire_en_c;

    function automatic logic [SEL_W-1:0] fwd_sel(
        input logic [REG_W-1:0] rs,
        input logic             used,
        input slot_t            x,
        input slot_t            w
    );
        logic [SEL_W-1:0] s;
        s = SEL_RF;
        if (rs == '0 || !used) begin
            s = SEL_RF;
        end else if (x.valid && x.we && x.rd == rs) begin
            s = x.is_load ? SEL_X_LOAD : SEL_ALU;
        end else if (w.valid && w.we && w.rd == rs) begin
            s = SEL_HOLD;
        end
        return s;
    endfunction

    // Load-use hazard detection, select computation and next X slot.
    always_comb begin
        stall_c = 1'b0;
`ifndef LOAD_FWD_EN
        stall_c = bus.d_valid && !bus.flush && x_q.valid && x_q.is_load && x_q.we &&
                  (x_q.rd != '0) &&
                  ((bus.d_rs1_used && bus.d_rs1 == x_q.rd) ||
                   (bus.d_rs2_used && bus.d_rs2 == x_q.rd));
`endif
        bubble_c    = bus.flush || stall_c || !bus.d_valid;
        retire_en_c = w_q.valid && w_q.we && (w_q.rd != '0);
        x_d         = '0;
        sel_a_d     = SEL_RF;
        sel_b_d     = SEL_RF;
        if (!bubble_c) begin
            x_d     = '{valid: 1'b1, rd: bus.d_rd, we: bus.d_we, is_load: bus.d_is_load};
            sel_a_d = fwd_sel(bus.d_rs1, bus.d_rs1_used, x_q, w_q);
            sel_b_d = fwd_sel(bus.d_rs2, bus.d_rs2_used, x_q, w_q);
        end
    end

    // Pipeline state; everything freezes while stall_in is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q         <= '0;
            w_q         <= '0;
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            retired_q   <= '0;
            stall_cnt_q <= '0;
        end else if (!bus.stall_in) begin
            x_q     <= x_d;
            w_q     <= x_q;
            sel_a_q <= sel_a_d;
            sel_b_q <= sel_b_d;
            if (retire_en_c) begin
                retired_q <= bus.w_wdata;
            end
            if (stall_c) begin
                stall_cnt_q <= stall_cnt_q + DATA_W'(1);
            end
        end
    end

    assign bus.sel_a        = sel_a_q;
    assign bus.sel_b        = sel_b_q;
    assign bus.retired_data = retired_q;
    assign bus.x_valid      = x_q.valid;
    assign bus.w_valid      = w_q.valid;
    assign bus.stall_d      = stall_c;
    assign bus.stall_cnt    = stall_cnt_q;
endmodule

// File: doc/operand_fwd_ctrl.md
# operand_fwd_ctrl

Forwarding and hazard controller for the three-stage D/X/W integer pipeline. Tracks destination registers of the instructions in X and W, produces registered 2-bit select codes for the X-stage operand A/B 4:1 multiplexers, holds the last retired writeback value as the fourth mux input, and stalls decode on a load-use hazard when load forwarding is compiled out. Sits between decode and the X-stage operand muxes; one instance serves both ALU operands.

## Interface
- No parameters; all widths are fixed: 5-bit register index, 32-bit data.
- clk  input  1  pipeline clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- stall_in  input  1  external pipeline freeze (memory wait); holds all state.
- flush  input  1  discards the instruction in D (taken branch/jump).
- d_valid  input  1  D holds a real instruction.
- d_rs1, d_rs2  input  5 each  source register indices.
- d_rs1_used, d_rs2_used  input  1 each  the operand is read from the register file.
- d_rd  input  5  destination index.
- d_we  input  1  instruction writes rd.
- d_is_load  input  1  instruction is a load.
- w_wdata  input  32  final writeback value of the instruction in W.
- sel_a, sel_b  output  2 each  operand mux selects for the instruction in X: 00 register file, 01 W ALU result, 10 W load data, 11 retired hold register.
- retired_data  output  32  hold register (mux input 11).
- x_valid, w_valid  output  1 each  slot occupancy.
- stall_d  output  1  freeze PC and D; X receives a bubble.
- stall_cnt  output  32  count of cycles with stall_d high.

## Operation
- Slots X and W each hold {valid, rd, we, is_load}; W is fed from X on every advance.
- Advance occurs on each edge with stall_in low. X loads from D unless flush or stall_d is high, in which case X receives a bubble (valid=0, we=0).
- Select per operand, computed from D and current slots, registered into sel_a/sel_b on advance:
  - rs==0 or rs_used==0 -> 00.
  - X.valid & X.we & X.rd==rs -> 10 if X.is_load, else 01. Highest priority.
  - else W.valid & W.we & W.rd==rs -> 11.
  - else 00.
- Bubble advance forces sel_a=sel_b=00.
- retired_data loads w_wdata on advance when W.valid & W.we & W.rd!=0; otherwise holds.
- stall_d = d_valid & ~flush & X.valid & X.is_load & X.we & X.rd!=0 & (rs1 or rs2 used and equal to X.rd); only when LOAD_FWD_EN is undefined; otherwise constant 0.
- stall_cnt increments by 1 on each edge where stall_d & ~stall_in; wraps 0xFFFFFFFF -> 0.
- stall_in high: no slot, select, hold-register or counter update; flush is ignored and must be held by the requester until stall_in is low.

## Timing
- Reset (asynchronous): x_valid=0, w_valid=0, sel_a=sel_b=00, retired_data=0, stall_cnt=0; stall_d therefore 0.
- sel_a/sel_b are valid in the same cycle their instruction occupies X (one cycle after it was in D).
- stall_d is combinational from D inputs and X slot; asserted for exactly one cycle per load-use hazard, then D advances with select 11.
- flush and stall_d in the same cycle: flush wins, stall_d=0, bubble enters X.
- Reset mid-stall releases stall_d immediately; D instruction then proceeds with select 00.

## Configuration
- LOAD_FWD_EN defined: load results forward from W (select 10); no load-use stall; stall_cnt stays 0.
- LOAD_FWD_EN undefined: select 10 never produced; load-use inserts one bubble, consumer then receives select 11.

## Test plan
- Reset mid-operation: assert rst with X/W full -> all outputs at reset values same cycle, before the next edge.
- ALU back-to-back: add x5 then sub x6,x5,x5 -> consumer in X with sel_a=sel_b=01; x0 producer (rd=0) -> 00.
- Distance two: add x7; nop; or x8,x7,x1 -> sel_a=11, sel_b=00, retired_data equals add result (e.g. 0x0000_1234).
- Load-use, LOAD_FWD_EN undefined: lw x9; addi x10,x9,1 -> stall_d high one cycle, bubble in X, then sel_a=11, stall_cnt=1; with macro defined -> no stall, sel_a=10.
- Flush vs stall: lw x9 in X, dependent in D with flush=1 -> stall_d=0, x_valid=0 next cycle, stall_cnt unchanged.
- stall_in held 3 cycles during a pending hazard -> sel, slots, retired_data and stall_cnt frozen; flush pulses during freeze have no effect.
